// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - multi-cycle fetch/decode sequencer driving the regfile/ALU/data-RAM datapath
// Fetches from a synchronous ROM into IR and sequences lw/sw/halt control strobes.
module fetch_decode_ctrl #(
   parameter int PC_W  = 6,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [31:0]      imem_data,
   output logic [PC_W-1:0]  imem_addr,
   output logic             Write_Reg,
   output logic             Mem_Write,
   output logic [2:0]       ALU_OP,
   output logic [15:0]      offset,
   output logic [4:0]       RS,
   output logic [4:0]       RT,
   output logic [4:0]       W_Addr,
   output logic             halted,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_IR_LD  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_HALT   = 3'd6;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [PC_W-1:0]  PC_ONE  = 1;
   localparam logic [CNT_W-1:0] CNT_ONE = 1;

   logic [2:0]       r_state;
   logic [PC_W-1:0]  r_pc;
   logic [31:0]      r_ir;
   logic [CNT_W-1:0] r_retired;
   logic             r_illegal;
   logic [5:0]       w_opcode;

   assign w_opcode = r_ir[31:26];

   always_ff @(posedge clk) begin
      if (Reset) begin
         r_state   <= S_FETCH;
         r_pc      <= '0;
         r_ir      <= '0;
         r_retired <= '0;
         r_illegal <= 1'b0;
      end else begin
         case (r_state)
            S_FETCH: r_state <= S_IR_LD;
            S_IR_LD: begin
               r_ir    <= imem_data;
               r_pc    <= r_pc + PC_ONE;
               r_state <= S_DECODE;
            end
            S_DECODE: begin
               case (w_opcode)
                  OP_LW, OP_SW: r_state <= S_EXEC;
                  OP_HALT:      r_state <= S_HALT;
                  default: begin
                     // Only the all-zero word is a nop; anything else lands here as illegal.
                     if (r_ir != 32'd0)
                        r_illegal <= 1'b1;
                     r_state <= S_FETCH;
                  end
               endcase
            end
            S_EXEC: r_state <= S_MEM;
            S_MEM: begin
               if (w_opcode == OP_SW) begin
                  r_retired <= r_retired + CNT_ONE;
                  r_state   <= S_FETCH;
               end else begin
                  r_state <= S_WB;
               end
            end
            S_WB: begin
               r_retired <= r_retired + CNT_ONE;
               r_state   <= S_FETCH;
            end
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_FETCH;
         endcase
      end
   end

   assign imem_addr = r_pc;
   assign ALU_OP    = 3'd4;
   assign offset    = r_ir[15:0];
   assign RS        = r_ir[25:21];
   assign RT        = r_ir[20:16];
   assign W_Addr    = r_ir[20:16];
   assign Write_Reg = (r_state == S_WB) && (r_ir[20:16] != 5'd0);
   assign Mem_Write = (r_state == S_MEM) && (w_opcode == OP_SW);
   // A decoded halt is reported from its DECODE cycle, one cycle before the HALT state proper.
   assign halted    = (r_state == S_HALT) || ((r_state == S_DECODE) && (w_opcode == OP_HALT));
   assign illegal   = r_illegal;
   assign retired   = r_retired;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - self-checking bench for fetch_decode_ctrl
// Vector table, hand sequences for halt/wrap/reset, and random programs against a timeline model.
module tb_fetch_decode_ctrl;
   localparam int PC_W  = 6;
   localparam int CNT_W = 16;
   localparam int NRUN  = 200;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             Reset;
   logic [31:0]      imem_data, imem_data2;
   logic [PC_W-1:0]  imem_addr;
   logic             Write_Reg, Mem_Write, halted, illegal;
   logic [2:0]       ALU_OP;
   logic [15:0]      offset;
   logic [4:0]       RS, RT, W_Addr;
   logic [CNT_W-1:0] retired;

   logic [1:0]       imem_addr2;
   logic             wr2, mw2, halted2, illegal2;
   logic [2:0]       alu2;
   logic [15:0]      off2;
   logic [4:0]       rs2, rt2, wa2;
   logic [CNT_W-1:0] ret2;

   logic [31:0] rom  [0:63];
   logic [31:0] rom2 [0:3];

   always @(posedge clk) imem_data  <= rom[imem_addr];
   always @(posedge clk) imem_data2 <= rom2[imem_addr2];

   fetch_decode_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .Reset(Reset), .imem_data(imem_data), .imem_addr(imem_addr),
      .Write_Reg(Write_Reg), .Mem_Write(Mem_Write), .ALU_OP(ALU_OP), .offset(offset),
      .RS(RS), .RT(RT), .W_Addr(W_Addr), .halted(halted), .illegal(illegal), .retired(retired)
   );

   fetch_decode_ctrl #(.PC_W(2), .CNT_W(CNT_W)) dut_small (
      .clk(clk), .Reset(Reset), .imem_data(imem_data2), .imem_addr(imem_addr2),
      .Write_Reg(wr2), .Mem_Write(mw2), .ALU_OP(alu2), .offset(off2),
      .RS(rs2), .RT(rt2), .W_Addr(wa2), .halted(halted2), .illegal(illegal2), .retired(ret2)
   );

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // per-cycle trace, index = cycle number after Reset release (cycle 1 = first FETCH)
   logic        tr_wr   [0:299];
   logic        tr_mw   [0:299];
   logic        tr_ill  [0:299];
   logic        tr_halt [0:299];
   logic [31:0] tr_addr [0:299];
   logic [31:0] tr_addr2[0:299];
   logic [15:0] tr_ret  [0:299];
   logic [4:0]  tr_rs   [0:299];
   logic [4:0]  tr_rt   [0:299];
   logic [4:0]  tr_wa   [0:299];
   logic [15:0] tr_off  [0:299];
   logic [2:0]  tr_alu  [0:299];

   task automatic do_reset();
      @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1;
      chk("rst_addr", 32'(imem_addr), 32'd0);
      chk("rst_retired", 32'(retired), 32'd0);
      chk("rst_illegal", 32'(illegal), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      chk("rst_strobes", {30'd0, Write_Reg, Mem_Write}, 32'd0);
      chk("rst_aluop", 32'(ALU_OP), 32'd4);
      Reset = 1'b0;
   endtask

   task automatic record(input int n);
      for (int k = 1; k <= n; k++) begin
         #1;
         tr_wr[k]    = Write_Reg;
         tr_mw[k]    = Mem_Write;
         tr_ill[k]   = illegal;
         tr_halt[k]  = halted;
         tr_addr[k]  = 32'(imem_addr);
         tr_addr2[k] = 32'(imem_addr2);
         tr_ret[k]   = retired;
         tr_rs[k]    = RS;
         tr_rt[k]    = RT;
         tr_wa[k]    = W_Addr;
         tr_off[k]   = offset;
         tr_alu[k]   = ALU_OP;
         @(negedge clk);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 64; i++) rom[i] = 32'd0;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [15:0] off;
      logic [7:0]  wr_mask;
      logic [7:0]  mw_mask;
      int          lat;
      logic [15:0] ret;
      logic        ill;
   } vec_t;

   vec_t vt[7];

   // reference model: expected per-cycle outputs from instruction latencies
   logic        exp_wr  [0:299];
   logic        exp_mw  [0:299];
   logic [15:0] exp_ret [0:299];
   int          exp_addr[0:299];
   int          inc     [0:299];
   int          ill_from, halt_from;

   task automatic model(input int n);
      int t, pc, acc;
      logic [31:0] w;
      for (int c = 0; c < 300; c++) begin
         exp_wr[c] = 1'b0; exp_mw[c] = 1'b0; exp_addr[c] = -1; inc[c] = 0;
      end
      ill_from = 1000; halt_from = 1000;
      t = 1; pc = 0;
      while (t <= n) begin
         w = rom[pc];
         exp_addr[t] = pc;
         pc = (pc + 1) % 64;
         if (w[31:26] == 6'h23) begin
            exp_wr[t+5] = (w[20:16] != 5'd0);
            inc[t+6]++;
            t += 6;
         end else if (w[31:26] == 6'h2b) begin
            exp_mw[t+4] = 1'b1;
            inc[t+5]++;
            t += 5;
         end else if (w[31:26] == 6'h3f) begin
            halt_from = t + 2;
            for (int c = t + 2; c <= n; c++) exp_addr[c] = pc;
            break;
         end else begin
            if (w != 32'd0 && ill_from > t + 3) ill_from = t + 3;
            t += 3;
         end
      end
      acc = 0;
      for (int c = 1; c <= n; c++) begin
         acc += inc[c];
         exp_ret[c] = 16'(acc);
      end
   endtask

   function automatic logic [31:0] rand_instr();
      int r;
      logic [5:0] op;
      r = $urandom_range(0, 15);
      if (r <= 5)       return {6'h23, 5'($urandom), 5'($urandom_range(0, 3) == 0 ? 0 : $urandom), 16'($urandom)};
      else if (r <= 10) return {6'h2b, 5'($urandom), 5'($urandom), 16'($urandom)};
      else if (r <= 12) return 32'd0;
      else if (r <= 14) begin
         op = 6'($urandom_range(1, 62));
         while (op == 6'h23 || op == 6'h2b) op = 6'($urandom_range(1, 62));
         return {op, 26'($urandom)};
      end else if ($urandom_range(0, 3) == 0) return 32'hFC00_0000;
      else return 32'd0;
   endfunction

   initial begin
      logic [7:0] wm, mm;
      Reset = 1'b1;
      for (int i = 0; i < 4; i++) rom2[i] = 32'd0;
      clear_rom();

      vt[0] = '{32'h8C43_0004, 5'd2,  5'd3,  16'h0004, 8'h20, 8'h00, 6, 16'd1, 1'b0};
      vt[1] = '{32'hAC45_0008, 5'd2,  5'd5,  16'h0008, 8'h00, 8'h10, 5, 16'd1, 1'b0};
      vt[2] = '{32'h8C40_0000, 5'd2,  5'd0,  16'h0000, 8'h00, 8'h00, 6, 16'd1, 1'b0};
      vt[3] = '{32'h8FFF_FFFC, 5'd31, 5'd31, 16'hFFFC, 8'h20, 8'h00, 6, 16'd1, 1'b0};
      vt[4] = '{32'hAFE0_0010, 5'd31, 5'd0,  16'h0010, 8'h00, 8'h10, 5, 16'd1, 1'b0};
      vt[5] = '{32'h0000_0000, 5'd0,  5'd0,  16'h0000, 8'h00, 8'h00, 3, 16'd0, 1'b0};
      vt[6] = '{32'h2083_1234, 5'd4,  5'd3,  16'h1234, 8'h00, 8'h00, 3, 16'd0, 1'b1};

      for (int v = 0; v < 7; v++) begin
         clear_rom();
         rom[0] = vt[v].instr;
         do_reset();
         record(8);
         wm = '0; mm = '0;
         for (int k = 1; k <= 8; k++) begin
            wm[k-1] = tr_wr[k];
            mm[k-1] = tr_mw[k];
         end
         chk($sformatf("v%0d_rs", v), 32'(tr_rs[3]), 32'(vt[v].rs));
         chk($sformatf("v%0d_rt", v), 32'(tr_rt[3]), 32'(vt[v].rt));
         chk($sformatf("v%0d_waddr", v), 32'(tr_wa[3]), 32'(vt[v].rt));
         chk($sformatf("v%0d_offset", v), 32'(tr_off[3]), 32'(vt[v].off));
         chk($sformatf("v%0d_aluop", v), 32'(tr_alu[3]), 32'd4);
         chk($sformatf("v%0d_wr_cycles", v), 32'(wm), 32'(vt[v].wr_mask));
         chk($sformatf("v%0d_mw_cycles", v), 32'(mm), 32'(vt[v].mw_mask));
         chk($sformatf("v%0d_next_fetch", v), tr_addr[vt[v].lat + 1], 32'd1);
         chk($sformatf("v%0d_retired", v), 32'(tr_ret[8]), 32'(vt[v].ret));
         chk($sformatf("v%0d_illegal", v), 32'(tr_ill[8]), 32'(vt[v].ill));
         chk($sformatf("v%0d_halted", v), 32'(tr_halt[8]), 32'd0);
      end

      // nop, illegal, halt: sticky illegal, halt from the 9th cycle, PC frozen
      clear_rom();
      rom[1] = 32'h2000_0000;
      rom[2] = 32'hFC00_0000;
      do_reset();
      record(14);
      chk("halt_ill_c6", 32'(tr_ill[6]), 32'd0);
      chk("halt_ill_c7", 32'(tr_ill[7]), 32'd1);
      chk("halt_ill_c14", 32'(tr_ill[14]), 32'd1);
      chk("halt_c8", 32'(tr_halt[8]), 32'd0);
      for (int k = 9; k <= 14; k++) begin
         chk($sformatf("halt_c%0d", k), 32'(tr_halt[k]), 32'd1);
         chk($sformatf("halt_pc_c%0d", k), tr_addr[k], 32'd3);
         chk($sformatf("halt_strobes_c%0d", k), {30'd0, tr_wr[k], tr_mw[k]}, 32'd0);
      end

      // PC wrap on the 2-bit instance, full-width instance keeps counting
      clear_rom();
      do_reset();
      record(13);
      for (int i = 0; i < 5; i++) begin
         chk($sformatf("wrap_small_f%0d", i), tr_addr2[1 + 3*i], 32'(i % 4));
         chk($sformatf("wrap_main_f%0d", i), tr_addr[1 + 3*i], 32'(i));
      end

      // Reset during WB of a lw drops the write and restarts at 0
      clear_rom();
      rom[0] = 32'h8C43_0004;
      do_reset();
      record(5);
      #1;
      chk("rwb_wr_before", 32'(Write_Reg), 32'd1);
      Reset = 1'b1;
      @(negedge clk);
      #1;
      chk("rwb_wr_after", 32'(Write_Reg), 32'd0);
      chk("rwb_pc", 32'(imem_addr), 32'd0);
      chk("rwb_retired", 32'(retired), 32'd0);
      chk("rwb_aluop", 32'(ALU_OP), 32'd4);
      Reset = 1'b0;
      record(7);
      chk("rwb_restart_addr", tr_addr[1], 32'd0);
      chk("rwb_rerun_wr", 32'(tr_wr[6]), 32'd1);
      chk("rwb_rerun_ret", 32'(tr_ret[7]), 32'd1);

      // random programs vs. timeline model
      for (int run = 0; run < 3; run++) begin
         for (int i = 0; i < 64; i++) rom[i] = rand_instr();
         model(NRUN);
         do_reset();
         record(NRUN);
         for (int c = 1; c <= NRUN; c++) begin
            chk($sformatf("r%0d_wr_c%0d", run, c), 32'(tr_wr[c]), 32'(exp_wr[c]));
            chk($sformatf("r%0d_mw_c%0d", run, c), 32'(tr_mw[c]), 32'(exp_mw[c]));
            chk($sformatf("r%0d_ret_c%0d", run, c), 32'(tr_ret[c]), 32'(exp_ret[c]));
            chk($sformatf("r%0d_ill_c%0d", run, c), 32'(tr_ill[c]), 32'(c >= ill_from));
            chk($sformatf("r%0d_halt_c%0d", run, c), 32'(tr_halt[c]), 32'(c >= halt_from));
            if (exp_addr[c] >= 0)
               chk($sformatf("r%0d_addr_c%0d", run, c), tr_addr[c], 32'(exp_addr[c]));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
